// File: rtl/stage_rr.sv
`default_nettype none
// ============================================================================
// Module   : stage_rr
// Purpose  : Register-read stage between decode and EX. Reads rs1/rs2 from
//            the architectural register file, bypasses the same-cycle
//            writeback result, and tracks in-flight writes per register in a
//            scoreboard so that operands with a pending producer stall.
//            Presents one registered operand packet to EX over valid/ready.
// Ports    : clk, rst_n (async, active low)
//            in_*      decode packet (valid, pc, rs1/rs2 + use, rd + w_rd)
//            in_ready  packet accepted this cycle (combinational)
//            regs      architectural register file from writeback
//            wb_*      writeback commit (w_rd, rd, res)
//            flush     kill the packet held in this stage
//            out_*     registered packet to EX, ex_ready is EX acceptance
// Revision : 1.0 - initial release
// ============================================================================
module stage_rr #(
  parameter int CNT_W = 2,
  parameter int NREGS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic                   in_use_rs1,
  input  logic                   in_use_rs2,
  input  logic [4:0]             in_rd,
  input  logic                   in_w_rd,
  input  logic [NREGS-1:0][31:0] regs,
  input  logic                   wb_w_rd,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_res,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   ex_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [4:0]             out_rd,
  output logic                   out_w_rd
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-register count of captured-but-not-yet-committed writes.
  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [NREGS-1:0] underflow;
  logic [CNT_W+1:0] sum_t;
  logic [CNT_W+1:0] sub_t;

  logic wb_hit1, wb_hit2;
  logic ok1, ok2, dest_ok;
  logic capture;
  logic [31:0] op1_val, op2_val;

  assign wb_hit1 = wb_w_rd && (wb_rd == in_rs1);
  assign wb_hit2 = wb_w_rd && (wb_rd == in_rs2);

  // Unused operands and x0 read as zero; a same-cycle commit wins over regs.
  assign op1_val = (!in_use_rs1 || in_rs1 == 5'd0) ? 32'd0 :
                   (wb_hit1 ? wb_res : regs[in_rs1]);
  assign op2_val = (!in_use_rs2 || in_rs2 == 5'd0) ? 32'd0 :
                   (wb_hit2 ? wb_res : regs[in_rs2]);

  // A single pending producer that is committing right now can be bypassed.
  assign ok1 = !in_use_rs1 || (in_rs1 == 5'd0) || (cnt[in_rs1] == '0) ||
               ((cnt[in_rs1] == CNT_ONE) && wb_hit1);
  assign ok2 = !in_use_rs2 || (in_rs2 == 5'd0) || (cnt[in_rs2] == '0) ||
               ((cnt[in_rs2] == CNT_ONE) && wb_hit2);

  // Refuse a new writer when its counter is already saturated.
  assign dest_ok = !in_w_rd || (in_rd == 5'd0) || (cnt[in_rd] != CNT_MAX);

  assign in_ready = rst_n && !flush && ok1 && ok2 && dest_ok &&
                    (!out_valid || ex_ready);
  assign capture  = in_valid && in_ready;

  // Net all same-cycle increments/decrements per register; x0 never counts.
  always_comb begin
    underflow = '0;
    sum_t     = '0;
    sub_t     = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = '0;
      if (r != 0) begin
        sum_t = {2'b00, cnt[r]} +
                {{(CNT_W+1){1'b0}}, (capture && in_w_rd && in_rd == 5'(r))};
        sub_t = {{(CNT_W+1){1'b0}}, (wb_w_rd && wb_rd == 5'(r))} +
                {{(CNT_W+1){1'b0}}, (flush && out_valid && out_w_rd &&
                                     out_rd == 5'(r))};
        if (sum_t < sub_t) begin
          underflow[r] = 1'b1;
          cnt_nxt[r]   = '0;
        end else begin
          cnt_nxt[r]   = CNT_W'(sum_t - sub_t);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  // A commit or flush of a register with nothing in flight is a protocol error.
  assert property (@(posedge clk) disable iff (!rst_n) underflow == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_w_rd  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_op1   <= op1_val;
      out_op2   <= op2_val;
      out_rd    <= in_rd;
      out_w_rd  <= in_w_rd;
    end else if (ex_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_rr
// Purpose  : Self-checking bench for stage_rr. A cycle-level reference model
//            (scoreboard counts + one held packet) is compared with the DUT on
//            every falling edge; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_pc = '0;
  logic [4:0]        in_rs1 = '0;
  logic [4:0]        in_rs2 = '0;
  logic              in_use_rs1 = 1'b0;
  logic              in_use_rs2 = 1'b0;
  logic [4:0]        in_rd = '0;
  logic              in_w_rd = 1'b0;
  logic [31:0][31:0] regs = '0;
  logic              wb_w_rd = 1'b0;
  logic [4:0]        wb_rd = '0;
  logic [31:0]       wb_res = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              ex_ready = 1'b0;
  logic [31:0]       out_pc, out_op1, out_op2;
  logic [4:0]        out_rd;
  logic              out_w_rd;

  stage_rr #(.CNT_W(2), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_w_rd(in_w_rd), .regs(regs),
    .wb_w_rd(wb_w_rd), .wb_rd(wb_rd), .wb_res(wb_res),
    .flush(flush), .out_valid(out_valid), .ex_ready(ex_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_w_rd(out_w_rd)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          mcnt [32];
  logic        mv, mw;
  logic [31:0] mpc, mop1, mop2;
  logic [4:0]  mrd;

  function automatic logic m_src_ok(input logic use_rs, input logic [4:0] rs);
    logic hit;
    hit = wb_w_rd && (wb_rd == rs);
    return !use_rs || rs == 5'd0 || mcnt[rs] == 0 || (mcnt[rs] == 1 && hit);
  endfunction

  function automatic logic [31:0] m_val(input logic use_rs, input logic [4:0] rs);
    if (!use_rs || rs == 5'd0) return 32'd0;
    if (wb_w_rd && wb_rd == rs) return wb_res;
    return regs[rs];
  endfunction

  always @(negedge clk) begin
    logic exp_ready, cap;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      mv = 1'b0; mw = 1'b0; mpc = '0; mop1 = '0; mop2 = '0; mrd = '0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      exp_ready = !flush && m_src_ok(in_use_rs1, in_rs1) &&
                  m_src_ok(in_use_rs2, in_rs2) &&
                  (!in_w_rd || in_rd == 5'd0 || mcnt[in_rd] < 3) &&
                  (!mv || ex_ready);
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    end
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, mv});
    chk("m_out_pc", out_pc, mpc);
    chk("m_out_op1", out_op1, mop1);
    chk("m_out_op2", out_op2, mop2);
    chk("m_out_rd", {27'd0, out_rd}, {27'd0, mrd});
    chk("m_out_w_rd", {31'd0, out_w_rd}, {31'd0, mw});
    for (int r = 0; r < 32; r++) chk($sformatf("m_cnt%0d", r), 32'(dut.cnt[r]), 32'(mcnt[r]));
    if (rst_n) begin
      // Predict the state after the coming rising edge (inputs are stable).
      cap = in_valid && exp_ready;
      if (cap && in_w_rd && in_rd != 5'd0) mcnt[in_rd]++;
      if (wb_w_rd && wb_rd != 5'd0) mcnt[wb_rd]--;
      if (flush && mv && mw && mrd != 5'd0) mcnt[mrd]--;
      for (int r = 0; r < 32; r++) if (mcnt[r] < 0) mcnt[r] = 0;
      if (flush) mv = 1'b0;
      else if (cap) begin
        mv = 1'b1; mpc = in_pc; mrd = in_rd; mw = in_w_rd;
        mop1 = m_val(in_use_rs1, in_rs1);
        mop2 = m_val(in_use_rs2, in_rs2);
      end else if (ex_ready) mv = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_use_rs1 = 0; in_use_rs2 = 0; in_w_rd = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0; wb_w_rd = 0; wb_rd = 0; flush = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    ex_ready = 1'b1;
    regs[5] = 32'h1234; regs[6] = 32'h5678; regs[3] = 32'h3333; regs[4] = 32'h4444;

    // 1: plain read with one-cycle latency
    step();
    in_valid = 1; in_pc = 32'h100; in_rs1 = 5; in_use_rs1 = 1;
    #1 chk("t1_ready", {31'd0, in_ready}, 32'd1);
    step(); idle();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_op1", out_op1, 32'h1234);
    chk("t1_pc", out_pc, 32'h100);

    // 2: RAW stall on rd=3 resolved by WB bypass
    step();
    in_valid = 1; in_pc = 32'h200; in_w_rd = 1; in_rd = 3;
    step(); idle();
    in_valid = 1; in_pc = 32'h204; in_rs1 = 3; in_use_rs1 = 1; in_rs2 = 5;
    #1 chk("t2_stall", {31'd0, in_ready}, 32'd0);
    step();
    wb_w_rd = 1; wb_rd = 3; wb_res = 32'hAA;
    #1 chk("t2_bypass_ready", {31'd0, in_ready}, 32'd1);
    step(); idle();
    chk("t2_op1", out_op1, 32'hAA);
    chk("t2_op2_unused", out_op2, 32'd0);
    chk("t2_cnt3", 32'(dut.cnt[3]), 32'd0);

    // 2b: same pattern through rs2
    step();
    in_valid = 1; in_pc = 32'h240; in_w_rd = 1; in_rd = 4;
    step(); idle();
    in_valid = 1; in_pc = 32'h244; in_rs2 = 4; in_use_rs2 = 1;
    wb_w_rd = 1; wb_rd = 4; wb_res = 32'hBB;
    step(); idle();
    chk("t2b_op2", out_op2, 32'hBB);

    // 3: counter saturation on rd=7
    step();
    in_valid = 1; in_pc = 32'h300; in_w_rd = 1; in_rd = 7;
    repeat (3) step();
    #1 chk("t3_cnt7", 32'(dut.cnt[7]), 32'd3);
    chk("t3_4th_stall", {31'd0, in_ready}, 32'd0);
    idle();
    wb_w_rd = 1; wb_rd = 7; wb_res = 32'h77;
    repeat (3) step();
    idle();
    chk("t3_cnt7_drained", 32'(dut.cnt[7]), 32'd0);

    // 4: flush of held writer to rd=9
    step();
    in_valid = 1; in_pc = 32'h400; in_w_rd = 1; in_rd = 9;
    step();
    ex_ready = 0; flush = 1; in_pc = 32'h404; in_rd = 10;
    #1 chk("t4_flush_no_accept", {31'd0, in_ready}, 32'd0);
    step(); idle(); ex_ready = 1;
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_cnt9", 32'(dut.cnt[9]), 32'd0);
    chk("t4_cnt10", 32'(dut.cnt[10]), 32'd0);

    // 5: x0 source and x0 writeback
    step();
    regs[0] = 32'h55;
    in_valid = 1; in_pc = 32'h500; in_rs1 = 0; in_use_rs1 = 1;
    wb_w_rd = 1; wb_rd = 0; wb_res = 32'hFF;
    #1 chk("t5_ready", {31'd0, in_ready}, 32'd1);
    step(); idle();
    chk("t5_op1", out_op1, 32'd0);
    chk("t5_cnt0", 32'(dut.cnt[0]), 32'd0);

    // 6: EX backpressure hold, then asynchronous reset mid-stall
    step();
    in_valid = 1; in_pc = 32'h600; in_rs1 = 5; in_rs2 = 6;
    in_use_rs1 = 1; in_use_rs2 = 1; in_w_rd = 1; in_rd = 12;
    step();
    ex_ready = 0; in_pc = 32'h604; in_rs1 = 1; in_rs2 = 2; in_rd = 13;
    #1 chk("t6_backpressure", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t6_hold_pc", out_pc, 32'h600);
      chk("t6_hold_op1", out_op1, 32'h1234);
      chk("t6_hold_op2", out_op2, 32'h5678);
      chk("t6_hold_rd", {27'd0, out_rd}, 32'd12);
    end
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_cnt12", 32'(dut.cnt[12]), 32'd0);
    chk("t6_rst_op1", out_op1, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    idle();
    step(); step();
    rst_n = 1'b1; ex_ready = 1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
